// File: rtl/burst_mem_responder.sv
// On-chip memory responder for the burst request/data interface: independent read and
// write burst engines sharing one 64B-wide dual-port RAM.
module burst_mem_responder #(
  parameter int DATA_W = 512,
  parameter int MEM_AW = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd_req,
  input  logic [7:0]        rd_len,
  input  logic [63:0]       rd_address,
  output logic              rd_req_ack,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic              rd_last,
  input  logic              wr_req,
  input  logic [7:0]        wr_len,
  input  logic [63:0]       wr_address,
  output logic              wr_req_ack,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_valid,
  output logic              wr_ready,
  output logic              bresp,
  input  logic              bready,
  output logic              addr_err,
  output logic [1:0]        dbg_rd_state,
  output logic [1:0]        dbg_wr_state
);

  // Handshake: a beat moves on any cycle where valid && ready are both high; a
  // valid beat holds data/last stable until ready. Request acks are one-cycle pulses.

  typedef enum logic [0:0] {R_IDLE = 1'b0, R_BURST = 1'b1} rd_state_t;
  typedef enum logic [1:0] {W_IDLE = 2'd0, W_DATA = 2'd1, W_RESP = 2'd2} wr_state_t;

  localparam logic [MEM_AW-1:0] IDX_ONE = {{(MEM_AW-1){1'b0}}, 1'b1};

  logic [DATA_W-1:0] r_mem [0:(1<<MEM_AW)-1];

  rd_state_t         r_rd_state;
  rd_state_t         w_rd_state_nxt;
  logic [MEM_AW-1:0] r_rd_idx;
  logic [8:0]        r_rd_cnt;
  logic              r_rd_ack;
  logic              r_s1_valid;
  logic              r_s1_last;
  logic [DATA_W-1:0] r_ram_q;
  logic [DATA_W-1:0] r_q0;
  logic [DATA_W-1:0] r_q1;
  logic              r_q0_last;
  logic              r_q1_last;
  logic [1:0]        r_fifo_cnt;
  logic              w_rd_accept;
  logic              w_rd_issue;
  logic              w_rd_pop;
  logic [2:0]        w_occ;

  wr_state_t         r_wr_state;
  wr_state_t         w_wr_state_nxt;
  logic [MEM_AW-1:0] r_wr_idx;
  logic [8:0]        r_wr_cnt;
  logic              r_wr_ack;
  logic              w_wr_accept;
  logic              w_wr_en;

  logic              r_addr_err;
  logic              w_unused;

  assign w_unused = ^{rd_address[63:MEM_AW+6], wr_address[63:MEM_AW+6]};

  // Read issue is credit-based: beats in the RAM stage plus beats in the 2-entry
  // output buffer never exceed two, so a stalled consumer cannot overflow it.
  always_comb begin
    w_rd_state_nxt = r_rd_state;
    w_rd_accept    = 1'b0;
    w_rd_issue     = 1'b0;
    w_rd_pop       = (r_fifo_cnt != 2'd0) && rd_ready;
    w_occ          = {1'b0, r_fifo_cnt} + {2'b00, r_s1_valid};
    case (r_rd_state)
      R_IDLE: begin
        if (rd_req) begin
          w_rd_accept    = 1'b1;
          w_rd_state_nxt = R_BURST;
        end
      end
      R_BURST: begin
        w_rd_issue = (r_rd_cnt != 9'd0) &&
                     ((w_occ < 3'd2) || (w_rd_pop && (w_occ == 3'd2)));
        if (w_rd_pop && r_q0_last) begin
          w_rd_state_nxt = R_IDLE;
        end
      end
      default: w_rd_state_nxt = R_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_state <= R_IDLE;
      r_rd_idx   <= '0;
      r_rd_cnt   <= '0;
      r_rd_ack   <= 1'b0;
      r_s1_valid <= 1'b0;
      r_s1_last  <= 1'b0;
    end else begin
      r_rd_state <= w_rd_state_nxt;
      r_rd_ack   <= w_rd_accept;
      if (w_rd_accept) begin
        r_rd_idx <= rd_address[MEM_AW+5:6];
        r_rd_cnt <= {1'b0, rd_len} + 9'd1;
      end else if (w_rd_issue) begin
        r_rd_idx <= r_rd_idx + IDX_ONE;
        r_rd_cnt <= r_rd_cnt - 9'd1;
      end
      r_s1_valid <= w_rd_issue;
      r_s1_last  <= w_rd_issue && (r_rd_cnt == 9'd1);
    end
  end

  // Output buffer: r_q0 is the presented beat, r_q1 the skid entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q0       <= '0;
      r_q1       <= '0;
      r_q0_last  <= 1'b0;
      r_q1_last  <= 1'b0;
      r_fifo_cnt <= 2'd0;
    end else if (w_rd_pop) begin
      if (r_s1_valid) begin
        if (r_fifo_cnt == 2'd1) begin
          r_q0      <= r_ram_q;
          r_q0_last <= r_s1_last;
        end else begin
          r_q0      <= r_q1;
          r_q0_last <= r_q1_last;
          r_q1      <= r_ram_q;
          r_q1_last <= r_s1_last;
        end
      end else begin
        r_q0       <= r_q1;
        r_q0_last  <= r_q1_last;
        r_fifo_cnt <= r_fifo_cnt - 2'd1;
      end
    end else if (r_s1_valid) begin
      if (r_fifo_cnt == 2'd0) begin
        r_q0      <= r_ram_q;
        r_q0_last <= r_s1_last;
      end else begin
        r_q1      <= r_ram_q;
        r_q1_last <= r_s1_last;
      end
      r_fifo_cnt <= r_fifo_cnt + 2'd1;
    end
  end

  always_comb begin
    w_wr_state_nxt = r_wr_state;
    w_wr_accept    = 1'b0;
    w_wr_en        = 1'b0;
    case (r_wr_state)
      W_IDLE: begin
        if (wr_req) begin
          w_wr_accept    = 1'b1;
          w_wr_state_nxt = W_DATA;
        end
      end
      W_DATA: begin
        if (wr_valid) begin
          w_wr_en = 1'b1;
          if (r_wr_cnt == 9'd1) begin
            w_wr_state_nxt = W_RESP;
          end
        end
      end
      W_RESP: begin
        if (bready) begin
          w_wr_state_nxt = W_IDLE;
        end
      end
      default: w_wr_state_nxt = W_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_state <= W_IDLE;
      r_wr_idx   <= '0;
      r_wr_cnt   <= '0;
      r_wr_ack   <= 1'b0;
      r_addr_err <= 1'b0;
    end else begin
      r_wr_state <= w_wr_state_nxt;
      r_wr_ack   <= w_wr_accept;
      if (w_wr_accept) begin
        r_wr_idx <= wr_address[MEM_AW+5:6];
        r_wr_cnt <= {1'b0, wr_len} + 9'd1;
      end else if (w_wr_en) begin
        r_wr_idx <= r_wr_idx + IDX_ONE;
        r_wr_cnt <= r_wr_cnt - 9'd1;
      end
      if ((w_rd_accept && (rd_address[5:0] != 6'd0)) ||
          (w_wr_accept && (wr_address[5:0] != 6'd0))) begin
        r_addr_err <= 1'b1;
      end
    end
  end

  // Nonblocking write and read in one block gives read-first behaviour on a same-word hit.
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_mem[r_wr_idx] <= wr_data;
    end
    if (w_rd_issue) begin
      r_ram_q <= r_mem[r_rd_idx];
    end
  end

  assign rd_req_ack   = r_rd_ack;
  assign rd_data      = r_q0;
  assign rd_valid     = (r_fifo_cnt != 2'd0);
  assign rd_last      = r_q0_last && (r_fifo_cnt != 2'd0);
  assign wr_req_ack   = r_wr_ack;
  assign wr_ready     = (r_wr_state == W_DATA);
  assign bresp        = (r_wr_state == W_RESP);
  assign addr_err     = r_addr_err;
  assign dbg_rd_state = {1'b0, r_rd_state};
  assign dbg_wr_state = r_wr_state;

endmodule

// File: tb/tb_burst_mem_responder.sv
// Directed bench for burst_mem_responder: write/read bursts, chaining, backpressure,
// wrap, misalignment, same-word concurrency and reset mid-burst.
module tb_burst_mem_responder;

  localparam int DATA_W = 512;
  localparam int MEM_AW = 10;
  localparam int DEPTH  = 1 << MEM_AW;

  logic              clk = 1'b0;
  logic              rst;
  logic              rd_req;
  logic [7:0]        rd_len;
  logic [63:0]       rd_address;
  logic              rd_req_ack;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              rd_ready;
  logic              rd_last;
  logic              wr_req;
  logic [7:0]        wr_len;
  logic [63:0]       wr_address;
  logic              wr_req_ack;
  logic [DATA_W-1:0] wr_data;
  logic              wr_valid;
  logic              wr_ready;
  logic              bresp;
  logic              bready;
  logic              addr_err;
  logic [1:0]        dbg_rd_state;
  logic [1:0]        dbg_wr_state;

  int n_tests = 0;
  int n_fail  = 0;
  logic [DATA_W-1:0] mdl [DEPTH];

  burst_mem_responder #(.DATA_W(DATA_W), .MEM_AW(MEM_AW)) dut (
    .clk(clk), .rst(rst),
    .rd_req(rd_req), .rd_len(rd_len), .rd_address(rd_address), .rd_req_ack(rd_req_ack),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_last(rd_last),
    .wr_req(wr_req), .wr_len(wr_len), .wr_address(wr_address), .wr_req_ack(wr_req_ack),
    .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .bresp(bresp), .bready(bready), .addr_err(addr_err),
    .dbg_rd_state(dbg_rd_state), .dbg_wr_state(dbg_wr_state)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_burst(input logic [63:0] addr, input int len,
                          input logic [DATA_W-1:0] base, input bit gaps, input string name);
    int idx, i, cyc, nack, nb;
    bit got, fire;
    idx = int'(addr[MEM_AW+5:6]);
    wr_address = addr; wr_len = 8'(len); wr_req = 1'b1;
    got = 1'b0;
    for (int c = 0; c < 20 && !got; c++) begin
      tick();
      if (wr_req_ack) got = 1'b1;
    end
    wr_req = 1'b0;
    n_tests++;
    if (!got) begin
      n_fail++;
      $display("FAIL %s_wr_ack: wr_req_ack not seen, required within 20 cycles", name);
      return;
    end
    i = 0; cyc = 0; nack = 0;
    while (i <= len && cyc < 2000) begin
      wr_valid = gaps ? ((cyc % 3) != 1) : 1'b1;
      wr_data  = base + DATA_W'(i);
      fire     = wr_valid && wr_ready;
      if (fire) mdl[(idx + i) % DEPTH] = wr_data;
      tick();
      if (fire) i++;
      if (wr_req_ack) nack++;
      cyc++;
    end
    wr_valid = 1'b0;
    n_tests++;
    if (i != len + 1) begin
      n_fail++;
      $display("FAIL %s_wr_beats: got %0d beats accepted, required %0d", name, i, len + 1);
    end
    n_tests++;
    if (nack != 0) begin
      n_fail++;
      $display("FAIL %s_wr_ack_once: got %0d extra ack cycles, required 0", name, nack);
    end
    n_tests++;
    if (wr_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_wr_ready_off: got wr_ready=%b after last beat, required 0", name, wr_ready);
    end
    nb = 0;
    for (int c = 0; c < 4; c++) begin
      if (bresp) nb++;
      tick();
    end
    n_tests++;
    if (nb != 1) begin
      n_fail++;
      $display("FAIL %s_bresp: got %0d bresp cycles, required 1", name, nb);
    end
  endtask

  task automatic rd_start(input logic [63:0] addr, input int len, input string name, output bit ok);
    rd_address = addr; rd_len = 8'(len); rd_req = 1'b1; ok = 1'b0;
    for (int c = 0; c < 20 && !ok; c++) begin
      tick();
      if (rd_req_ack) ok = 1'b1;
    end
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s_rd_ack: rd_req_ack not seen, required within 20 cycles", name);
    end
  endtask

  // Called in the rd_req_ack cycle; pat 0 = ready always, 1 = ready 1,0,0,1 repeating.
  task automatic rd_collect(input int n, input int start_idx, input int pat, input string name);
    int got_n, first_k, last_k, stall_bad, data_bad, last_bad, extra_ack;
    bit pv, pr, pl;
    logic [DATA_W-1:0] pd;
    got_n = 0; first_k = -1; last_k = -1;
    stall_bad = 0; data_bad = 0; last_bad = 0; extra_ack = 0;
    pv = 1'b0; pr = 1'b1; pl = 1'b0; pd = '0;
    for (int k = 0; k < n * 4 + 20 && got_n < n; k++) begin
      if (k > 0 && rd_req_ack) extra_ack++;
      if (pv && !pr) begin
        if (rd_valid !== 1'b1 || rd_data !== pd || rd_last !== pl) stall_bad++;
      end
      rd_ready = (pat == 0) ? 1'b1 : (((k % 4) == 0) || ((k % 4) == 3));
      if (rd_valid) begin
        if (first_k < 0) first_k = k;
        if (rd_data !== mdl[(start_idx + got_n) % DEPTH]) begin
          if (data_bad == 0)
            $display("FAIL %s_data: beat %0d got %0h, required %0h", name, got_n,
                     rd_data[63:0], mdl[(start_idx + got_n) % DEPTH][63:0]);
          data_bad++;
        end
        if (rd_last !== (got_n == n - 1)) last_bad++;
        if (rd_ready) begin
          got_n++;
          last_k = k;
        end
      end
      pv = rd_valid; pr = rd_ready; pd = rd_data; pl = rd_last;
      tick();
    end
    rd_ready = 1'b1;
    n_tests++;
    if (got_n != n) begin
      n_fail++;
      $display("FAIL %s_count: got %0d beats, required %0d", name, got_n, n);
    end
    n_tests++;
    if (data_bad != 0) n_fail++;
    n_tests++;
    if (last_bad != 0) begin
      n_fail++;
      $display("FAIL %s_last: got %0d wrong rd_last cycles, required 0", name, last_bad);
    end
    n_tests++;
    if (stall_bad != 0) begin
      n_fail++;
      $display("FAIL %s_stall: got %0d unstable stalled cycles, required 0", name, stall_bad);
    end
    n_tests++;
    if (extra_ack != 0) begin
      n_fail++;
      $display("FAIL %s_ack_once: got %0d extra rd_req_ack cycles, required 0", name, extra_ack);
    end
    n_tests++;
    if (first_k != 2) begin
      n_fail++;
      $display("FAIL %s_latency: first rd_valid %0d cycles after ack, required 2", name, first_k);
    end
    if (pat == 0) begin
      n_tests++;
      if (last_k != first_k + n - 1) begin
        n_fail++;
        $display("FAIL %s_throughput: last beat at cycle %0d, required %0d", name, last_k, first_k + n - 1);
      end
    end
    n_tests++;
    if (rd_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_no_extra: got rd_valid=%b after last beat, required 0", name, rd_valid);
    end
  endtask

  task automatic rd_burst(input logic [63:0] addr, input int len, input int pat, input string name);
    bit ok;
    rd_start(addr, len, name, ok);
    rd_req = 1'b0;
    if (ok) rd_collect(len + 1, int'(addr[MEM_AW+5:6]), pat, name);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    rd_req = 0; rd_len = 0; rd_address = 0; rd_ready = 1'b1;
    wr_req = 0; wr_len = 0; wr_address = 0; wr_data = '0; wr_valid = 0; bready = 1'b1;
    repeat (3) tick();
    n_tests++;
    if ({rd_req_ack, rd_valid, rd_last, wr_req_ack, wr_ready, bresp, addr_err} !== 7'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b, required 0000000",
               {rd_req_ack, rd_valid, rd_last, wr_req_ack, wr_ready, bresp, addr_err});
    end
    n_tests++;
    if (rd_data !== '0) begin
      n_fail++;
      $display("FAIL reset_rd_data: got %0h, required 0", rd_data[63:0]);
    end
    n_tests++;
    if ({dbg_rd_state, dbg_wr_state} !== 4'b0) begin
      n_fail++;
      $display("FAIL reset_fsm: got %b, required 0000", {dbg_rd_state, dbg_wr_state});
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_write_read();
    wr_burst(64'h1000, 63, '0, 1'b0, "wr1");
    rd_burst(64'h1000, 63, 0, "rd1");
  endtask

  task automatic test_chained();
    bit ok, got;
    int c;
    wr_burst(64'h2000, 5, {16{32'h2000_0000}}, 1'b0, "wr_chain");
    rd_start(64'h1000, 63, "chain1", ok);
    if (!ok) begin
      rd_req = 1'b0;
      return;
    end
    rd_address = 64'h2000; rd_len = 8'd5;
    rd_collect(64, 64, 0, "chain1");
    got = 1'b0; c = 0;
    while (!got && c < 8) begin
      if (rd_req_ack) got = 1'b1;
      else begin
        tick();
        c++;
      end
    end
    rd_req = 1'b0;
    n_tests++;
    if (!got || c < 1) begin
      n_fail++;
      $display("FAIL chain_second_ack: got ack %0d cycles after last beat (seen=%b), required 1..7", c, got);
      return;
    end
    rd_collect(6, 128, 0, "chain2");
  endtask

  task automatic test_backpressure();
    wr_burst(64'h3000, 15, {16{32'h3000_0000}}, 1'b1, "wr_gap");
    rd_burst(64'h3000, 15, 1, "rd_bp");
  endtask

  task automatic test_wrap_misalign();
    n_tests++;
    if (addr_err !== 1'b0) begin
      n_fail++;
      $display("FAIL addr_err_clean: got %b, required 0", addr_err);
    end
    wr_burst(64'hFFC0, 1, {16{32'hC0DE_0000}}, 1'b0, "wr_wrap");
    rd_burst(64'hFFC0, 1, 0, "rd_wrap");
    n_tests++;
    if (addr_err !== 1'b0) begin
      n_fail++;
      $display("FAIL addr_err_aligned: got %b, required 0", addr_err);
    end
    rd_burst(64'h0010, 0, 0, "rd_mis");
    n_tests++;
    if (addr_err !== 1'b1) begin
      n_fail++;
      $display("FAIL addr_err_set: got %b, required 1", addr_err);
    end
  endtask

  task automatic test_concurrent();
    logic [DATA_W-1:0] old_v, new_v, seen;
    int seen_k, nb;
    bit got;
    old_v = {16{32'h5555_0005}};
    new_v = {16{32'hAAAA_000A}};
    wr_burst(64'h140, 0, old_v, 1'b0, "wr_cc");
    rd_address = 64'h140; rd_len = 0; wr_address = 64'h140; wr_len = 0;
    rd_req = 1'b1; wr_req = 1'b1; rd_ready = 1'b1;
    got = 1'b0;
    for (int c = 0; c < 20 && !got; c++) begin
      tick();
      if (rd_req_ack || wr_req_ack) got = 1'b1;
    end
    rd_req = 1'b0; wr_req = 1'b0;
    n_tests++;
    if ({rd_req_ack, wr_req_ack} !== 2'b11) begin
      n_fail++;
      $display("FAIL cc_both_ack: got rd/wr ack %b, required 11", {rd_req_ack, wr_req_ack});
    end
    wr_valid = 1'b1; wr_data = new_v;
    seen = '0; seen_k = -1; nb = 0;
    for (int k = 1; k <= 6; k++) begin
      tick();
      wr_valid = 1'b0;
      if (rd_valid && seen_k < 0) begin
        seen = rd_data;
        seen_k = k;
      end
      if (bresp) nb++;
    end
    mdl[5] = new_v;
    n_tests++;
    if (seen !== old_v || seen_k != 2) begin
      n_fail++;
      $display("FAIL cc_read_first: got %0h at cycle %0d, required %0h at cycle 2",
               seen[63:0], seen_k, old_v[63:0]);
    end
    n_tests++;
    if (nb != 1) begin
      n_fail++;
      $display("FAIL cc_bresp: got %0d bresp cycles, required 1", nb);
    end
    rd_burst(64'h140, 0, 0, "cc_new");
  endtask

  task automatic test_reset_mid_burst();
    bit ok;
    int acc, nv;
    wr_address = 64'h5000; wr_len = 8'd63; wr_req = 1'b1;
    rd_start(64'h1000, 63, "rst_rd", ok);
    rd_req = 1'b0; wr_req = 1'b0;
    if (!ok) return;
    acc = 0;
    for (int c = 0; c < 200 && acc < 10; c++) begin
      if (rd_valid) acc++;
      tick();
    end
    rst = 1'b1;
    #1;
    n_tests++;
    if ({rd_valid, rd_last, bresp, wr_ready, addr_err} !== 5'b0) begin
      n_fail++;
      $display("FAIL rst_mid_outputs: got %b, required 00000", {rd_valid, rd_last, bresp, wr_ready, addr_err});
    end
    n_tests++;
    if ({dbg_rd_state, dbg_wr_state} !== 4'b0) begin
      n_fail++;
      $display("FAIL rst_mid_fsm: got %b, required 0000", {dbg_rd_state, dbg_wr_state});
    end
    repeat (3) tick();
    rst = 1'b0;
    nv = 0;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (rd_valid || bresp || wr_ready) nv++;
    end
    n_tests++;
    if (nv != 0) begin
      n_fail++;
      $display("FAIL rst_mid_trailing: got %0d cycles with activity, required 0", nv);
    end
    rd_burst(64'h1000, 3, 0, "rst_after");
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_chained();
    test_backpressure();
    test_wrap_misalign();
    test_concurrent();
    test_reset_mid_burst();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
